pixel_loader: RTL

PIXEL_LOADER -- requirements
Module: pixel_loader

---
 rtl/pixel_loader.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pixel_loader.sv
// pixel_loader: fetches image bytes four at a time and hands each group to a CPU pixel bank.
// Build macro PIX_PAD_EN: round a partial final group up and write it with unused lanes at zero.
module pixel_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] img_base,
    input  logic [31:0] pix_count,
    input  logic [31:0] cte1,
    input  logic [31:0] cte2,
    input  logic [31:0] cte3,
    input  logic [31:0] cte4,
    input  logic [7:0]  mem_rdata,
    input  logic        cpu_ready,
    output logic        mem_rd,
    output logic [31:0] mem_addr,
    output logic [31:0] wdp1,
    output logic [31:0] wdp2,
    output logic [31:0] wdp3,
    output logic [31:0] wdp4,
    output logic        we_pxl,
    output logic        wr_pos_pxl,
    output logic [31:0] wdm1,
    output logic [31:0] wdm2,
    output logic [31:0] wdm3,
    output logic [31:0] wdm4,
    output logic        we_mul,
    output logic        busy,
    output logic        done,
    output logic [15:0] groups_wr
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_CTE  = 3'd1;
    localparam logic [2:0] ST_RD   = 3'd2;
    localparam logic [2:0] ST_CAP  = 3'd3;
    localparam logic [2:0] ST_WR   = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

    function automatic logic [31:0] group_total(input logic [31:0] pc);
`ifdef PIX_PAD_EN
        return (pc >> 5'd2) + {31'd0, |pc[1:0]};
`else
        return pc >> 5'd2;
`endif
    endfunction

    logic [2:0]  state_r, state_s;
    logic [1:0]  sub_r, sub_s;
    logic [31:0] grp_r, grp_s;
    logic [31:0] base_r, pcount_r, ngroups_r;
    logic [7:0]  lane_r [4];
    logic        cap_pend_r, cap_rd_r;
    logic [1:0]  cap_idx_r;
    logic        accept_s, rd_s;
    logic [33:0] idx_s;
    logic [31:0] addr_s;

    assign wdp1 = {24'd0, lane_r[0]};
    assign wdp2 = {24'd0, lane_r[1]};
    assign wdp3 = {24'd0, lane_r[2]};
    assign wdp4 = {24'd0, lane_r[3]};

    // Next state plus the read strobe/address of the cycle being entered (outputs are registered).
    always_comb begin
        state_s  = state_r;
        sub_s    = sub_r;
        grp_s    = grp_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_CTE;
                    sub_s   = 2'd0;
                    grp_s   = 32'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CTE: begin
                sub_s = 2'd0;
                grp_s = 32'd0;
                if (ngroups_r == 32'd0) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RD;
                end
            end
            ST_RD: begin
                if (sub_r == 2'd3) begin
                    state_s = ST_CAP;
                end else begin
                    sub_s = sub_r + 2'd1;
                end
            end
            ST_CAP:  state_s = ST_WR;
            ST_WR: begin
                if (cpu_ready) begin
                    accept_s = 1'b1;
                    if (grp_r + 32'd1 == ngroups_r) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RD;
                        grp_s   = grp_r + 32'd1;
                        sub_s   = 2'd0;
                    end
                end else begin
                    state_s = ST_WR;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
        idx_s  = {grp_s, 2'b00} + {32'd0, sub_s};
        rd_s   = (state_s == ST_RD) && (idx_s < {2'b00, pcount_r});
        addr_s = (state_s == ST_RD) ? (base_r + idx_s[31:0]) : 32'd0;
    end

    // State, job parameters, registered outputs and the one-cycle-late read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            sub_r      <= 2'd0;
            grp_r      <= 32'd0;
            base_r     <= 32'd0;
            pcount_r   <= 32'd0;
            ngroups_r  <= 32'd0;
            cap_pend_r <= 1'b0;
            cap_rd_r   <= 1'b0;
            cap_idx_r  <= 2'd0;
            for (int i = 0; i < 4; i++) lane_r[i] <= 8'd0;
            mem_rd     <= 1'b0;
            mem_addr   <= 32'd0;
            we_pxl     <= 1'b0;
            wr_pos_pxl <= 1'b0;
            wdm1       <= 32'd0;
            wdm2       <= 32'd0;
            wdm3       <= 32'd0;
            wdm4       <= 32'd0;
            we_mul     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            groups_wr  <= 16'd0;
        end else begin
            state_r  <= state_s;
            sub_r    <= sub_s;
            grp_r    <= grp_s;
            mem_rd   <= rd_s;
            mem_addr <= addr_s;
            we_mul   <= (state_s == ST_CTE);
            we_pxl   <= (state_s == ST_WR);
            done     <= (state_s == ST_DONE);
            busy     <= (state_s == ST_CTE) || (state_s == ST_RD) ||
                        (state_s == ST_CAP) || (state_s == ST_WR);
            if ((state_r == ST_IDLE) && start) begin
                base_r     <= img_base;
                pcount_r   <= pix_count;
                ngroups_r  <= group_total(pix_count);
                wdm1       <= cte1;
                wdm2       <= cte2;
                wdm3       <= cte3;
                wdm4       <= cte4;
                groups_wr  <= 16'd0;
                wr_pos_pxl <= 1'b0;
            end else if (accept_s) begin
                if (groups_wr != 16'hFFFF) groups_wr <= groups_wr + 16'd1;
                wr_pos_pxl <= ~wr_pos_pxl;
            end
            // Data for the read issued last cycle is on mem_rdata now; skipped reads load zero.
            cap_pend_r <= (state_r == ST_RD);
            cap_idx_r  <= sub_r;
            cap_rd_r   <= mem_rd;
            if (cap_pend_r) lane_r[cap_idx_r] <= cap_rd_r ? mem_rdata : 8'd0;
        end
    end

endmodule
